wb_irq_cond_8: RTL and testbench

//  Interrupt input conditioner that sits directly upstream of the 8-input PIC and drives its int_in bus.
//  - Per channel: synchronises an asynchronous external line and optionally debounces it.
//  - Converts the line into either an active level or a one-cycle edge pulse.
//  - Mode, polarity and debounce threshold are set through a Wishbone slave register file.

---
 rtl/wb_irq_cond_8.sv | 132 +++++++++++++
 tb/tb_wb_irq_cond_8.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_irq_cond_8.sv
// Interrupt input conditioner for the 8-input PIC: synchroniser, optional debounce
// (IRQ_COND_DEBOUNCE_EN), level/edge conversion, sticky events, Wishbone registers.
module wb_irq_cond_8 #(
  parameter int unsigned N_IRQ       = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DB_W        = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       wb_addr,
  input  logic [31:0]      wb_wdata,
  input  logic             wb_we,
  input  logic             wb_stb,
  output logic [31:0]      wb_rdata,
  output logic             wb_ack,
  input  logic [N_IRQ-1:0] irq_raw,
  output logic [N_IRQ-1:0] int_out
);

  localparam int unsigned DW = 32;
  localparam logic [7:0] A_TYPE   = 8'h00;
  localparam logic [7:0] A_POL    = 8'h04;
  localparam logic [7:0] A_DB     = 8'h08;
  localparam logic [7:0] A_SYNC   = 8'h0C;
  localparam logic [7:0] A_STABLE = 8'h10;
  localparam logic [7:0] A_EVT    = 8'h14;

  logic [N_IRQ-1:0] sync_q [SYNC_STAGES];
  logic [N_IRQ-1:0] sync;
  logic [N_IRQ-1:0] stable_q;
  logic [N_IRQ-1:0] stable_d_q;
  logic [N_IRQ-1:0] type_q;
  logic [N_IRQ-1:0] pol_q;
  logic [N_IRQ-1:0] evt_q;
  logic [N_IRQ-1:0] int_nxt;
  logic [N_IRQ-1:0] evt_clr;
  logic [DW-1:0]    rd_mux;
  logic             wr;
  logic             wdata_unused_c;

  assign wr             = wb_stb & wb_we;
  assign sync           = sync_q[SYNC_STAGES-1];
  assign wdata_unused_c = ^wb_wdata;

  // Metastability chain per channel
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
    end else begin
      sync_q[0] <= irq_raw;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end

`ifdef IRQ_COND_DEBOUNCE_EN
  logic [DB_W-1:0] db_thresh_q;
  logic [DB_W-1:0] cnt_q [N_IRQ];

  // >= so a threshold lowered below a running count still resolves next mismatch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable_q <= '0;
      for (int i = 0; i < N_IRQ; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < N_IRQ; i++) begin
        if (sync[i] == stable_q[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] >= db_thresh_q) begin
          stable_q[i] <= sync[i];
          cnt_q[i]    <= '0;
        end else begin
          cnt_q[i] <= cnt_q[i] + DB_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       db_thresh_q <= '0;
    else if (wr && wb_addr == A_DB)   db_thresh_q <= wb_wdata[DB_W-1:0];
  end
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stable_q <= '0;
    else        stable_q <= sync;
  end
`endif

  // Edge mode keys off raw stable transitions so POL/TYPE changes never pulse
  always_comb begin
    int_nxt = (type_q & ((pol_q & stable_d_q & ~stable_q) | (~pol_q & stable_q & ~stable_d_q)))
            | (~type_q & (stable_q ^ pol_q));
    evt_clr = (wr && wb_addr == A_EVT) ? wb_wdata[N_IRQ-1:0] : '0;
  end

  always_comb begin
    rd_mux = '0;
    case (wb_addr)
      A_TYPE:   rd_mux[N_IRQ-1:0] = type_q;
      A_POL:    rd_mux[N_IRQ-1:0] = pol_q;
`ifdef IRQ_COND_DEBOUNCE_EN
      A_DB:     rd_mux[DB_W-1:0]  = db_thresh_q;
`endif
      A_SYNC:   rd_mux[N_IRQ-1:0] = sync;
      A_STABLE: rd_mux[N_IRQ-1:0] = stable_q;
      A_EVT:    rd_mux[N_IRQ-1:0] = evt_q;
      default:  rd_mux = '0;
    endcase
  end

  // Registers, outputs and bus response; a new event wins over a same-cycle clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable_d_q <= '0;
      type_q     <= '0;
      pol_q      <= '0;
      evt_q      <= '0;
      int_out    <= '0;
      wb_ack     <= 1'b0;
      wb_rdata   <= '0;
    end else begin
      stable_d_q <= stable_q;
      int_out    <= int_nxt;
      evt_q      <= (evt_q & ~evt_clr) | (int_nxt & ~int_out);
      wb_ack     <= wb_stb;
      if (wb_stb) wb_rdata <= rd_mux;
      if (wr && wb_addr == A_TYPE) type_q <= wb_wdata[N_IRQ-1:0];
      if (wr && wb_addr == A_POL)  pol_q  <= wb_wdata[N_IRQ-1:0];
    end
  end

endmodule

// File: tb/tb_wb_irq_cond_8.sv
// Scoreboard bench for wb_irq_cond_8: stimulus queues expected int_out samples and
// bus responses; a negedge monitor pops and compares them.
module tb_wb_irq_cond_8;

  logic        clk;
  logic        rst_n;
  logic [7:0]  wb_addr;
  logic [31:0] wb_wdata;
  logic        wb_we;
  logic        wb_stb;
  logic [31:0] wb_rdata;
  logic        wb_ack;
  logic [7:0]  irq_raw;
  logic [7:0]  int_out;

`ifdef IRQ_COND_DEBOUNCE_EN
  localparam bit DB_EN = 1'b1;
`else
  localparam bit DB_EN = 1'b0;
`endif

  wb_irq_cond_8 dut (
    .clk(clk), .rst_n(rst_n), .wb_addr(wb_addr), .wb_wdata(wb_wdata),
    .wb_we(wb_we), .wb_stb(wb_stb), .wb_rdata(wb_rdata), .wb_ack(wb_ack),
    .irq_raw(irq_raw), .int_out(int_out)
  );

  typedef struct { int cyc; logic [7:0] mask; logic [7:0] val; } iexp_t;
  typedef struct { int cyc; bit chk; logic [7:0] addr; logic [31:0] val; } bexp_t;

  iexp_t iq[$];
  bexp_t bq[$];
  iexp_t ie;
  bexp_t be;
  int    cyc;
  int    n_chk;
  int    n_pass;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor
  always @(negedge clk) begin
    while (iq.size() > 0 && iq[0].cyc <= cyc) begin
      ie = iq.pop_front();
      n_chk++;
      if (ie.cyc != cyc)
        $display("FAIL int_out sample cyc=%0d missed (now %0d)", ie.cyc, cyc);
      else if ((int_out & ie.mask) == ie.val)
        n_pass++;
      else
        $display("FAIL int_out cyc=%0d mask=%h got=%h exp=%h", cyc, ie.mask, int_out & ie.mask, ie.val);
    end
    if (wb_ack) begin
      n_chk++;
      if (bq.size() == 0) begin
        $display("FAIL wb_ack unexpected at cyc=%0d", cyc);
      end else begin
        be = bq.pop_front();
        if (be.cyc != cyc)
          $display("FAIL wb_ack timing addr=%h got cyc=%0d exp cyc=%0d", be.addr, cyc, be.cyc);
        else if (be.chk && wb_rdata !== be.val)
          $display("FAIL wb_rdata addr=%h got=%h exp=%h", be.addr, wb_rdata, be.val);
        else
          n_pass++;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expi(input int c, input logic [7:0] m, input logic [7:0] v);
    iexp_t e;
    e.cyc = c; e.mask = m; e.val = v;
    iq.push_back(e);
  endtask

  task automatic wb_xfer(input logic [7:0] a, input logic [31:0] d, input bit we, input logic [31:0] exp);
    bexp_t e;
    e.cyc = cyc + 1; e.chk = !we; e.addr = a; e.val = exp;
    bq.push_back(e);
    wb_addr = a; wb_wdata = d; wb_we = we; wb_stb = 1'b1;
    tick(1);
    wb_stb = 1'b0; wb_we = 1'b0;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    wb_xfer(a, d, 1'b1, 32'h0);
  endtask

  task automatic rd(input logic [7:0] a, input logic [31:0] exp);
    wb_xfer(a, 32'h0, 1'b0, exp);
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", nm, got, exp);
  endtask

  int k;
  int j;

  initial begin
    cyc = 0; n_chk = 0; n_pass = 0;
    rst_n = 1'b0; wb_addr = '0; wb_wdata = '0; wb_we = 1'b0; wb_stb = 1'b0; irq_raw = '0;
    tick(3);
    rst_n = 1'b1;
    tick(1);

    // Reset state
    expi(cyc + 1, 8'hFF, 8'h00);
    rd(8'h00, 0); rd(8'h04, 0); rd(8'h08, 0); rd(8'h0C, 0); rd(8'h10, 0); rd(8'h14, 0);

    // Bus behaviour, field widths, unmapped offsets, level-mode EVT
    wr(8'h00, 32'h0000_00A5);
    rd(8'h00, 32'h0000_00A5);
    rd(8'h3C, 0);
    wr(8'h3C, 32'hFFFF_FFFF);
    rd(8'h3C, 0);
    wr(8'h04, 32'hFFFF_FF3C);
    rd(8'h04, 32'h0000_003C);
    wr(8'h04, 0);
    wr(8'h00, 0);
    rd(8'h14, 32'h0000_0018);
    wr(8'h14, 32'h0000_00FF);
    rd(8'h14, 0);
    wr(8'h08, 32'h0000_01FF);
    rd(8'h08, DB_EN ? 32'h0000_00FF : 32'h0);
    wr(8'h08, 0);

    // Level mode latency on channel 0
    k = cyc;
    irq_raw[0] = 1'b1;
    expi(k + 3, 8'h01, 8'h00);
    expi(k + 4, 8'h01, 8'h01);
    tick(5);
    rd(8'h0C, 32'h01);
    rd(8'h10, 32'h01);
    expi(cyc + 2, 8'h01, 8'h01);
    tick(3);
    j = cyc;
    irq_raw[0] = 1'b0;
    expi(j + 3, 8'h01, 8'h01);
    expi(j + 4, 8'h01, 8'h00);
    tick(6);
    rd(8'h14, 32'h01);
    wr(8'h14, 32'h01);
    rd(8'h14, 0);

    // Rising-edge mode on channel 1
    wr(8'h00, 32'h02);
    k = cyc;
    irq_raw[1] = 1'b1;
    expi(k + 3, 8'h02, 8'h00);
    expi(k + 4, 8'h02, 8'h02);
    expi(k + 5, 8'h02, 8'h00);
    expi(k + 12, 8'h02, 8'h00);
    tick(20);
    rd(8'h14, 32'h02);
    wr(8'h14, 32'h02);
    rd(8'h14, 0);
    j = cyc;
    irq_raw[1] = 1'b0;
    expi(j + 4, 8'h02, 8'h00);
    expi(j + 5, 8'h02, 8'h00);
    tick(8);
    rd(8'h14, 0);

    // Falling-edge mode on channel 2, POL toggle while idle
    wr(8'h00, 32'h04);
    wr(8'h04, 32'h04);
    k = cyc;
    irq_raw[2] = 1'b1;
    expi(k + 4, 8'h04, 8'h00);
    expi(k + 5, 8'h04, 8'h00);
    tick(8);
    j = cyc;
    irq_raw[2] = 1'b0;
    expi(j + 3, 8'h04, 8'h00);
    expi(j + 4, 8'h04, 8'h04);
    expi(j + 5, 8'h04, 8'h00);
    tick(8);
    rd(8'h14, 32'h04);
    for (int c = 1; c <= 6; c++) expi(cyc + c, 8'h04, 8'h00);
    wr(8'h04, 0);
    wr(8'h04, 32'h04);
    tick(4);
    wr(8'h04, 0);
    wr(8'h00, 0);
    wr(8'h14, 32'hFF);

`ifdef IRQ_COND_DEBOUNCE_EN
    // Debounce threshold 5: 5-cycle glitch rejected, 6-cycle pulse accepted
    wr(8'h08, 32'h05);
    k = cyc;
    irq_raw[3] = 1'b1;
    for (int c = 3; c <= 13; c++) expi(k + c, 8'h08, 8'h00);
    tick(5);
    irq_raw[3] = 1'b0;
    tick(8);
    rd(8'h10, 0);
    tick(2);
    j = cyc;
    irq_raw[3] = 1'b1;
    expi(j + 8, 8'h08, 8'h00);
    expi(j + 9, 8'h08, 8'h08);
    expi(j + 14, 8'h08, 8'h08);
    expi(j + 15, 8'h08, 8'h00);
    tick(6);
    irq_raw[3] = 1'b0;
    tick(3);
    rd(8'h10, 32'h08);
    tick(8);
    rd(8'h14, 32'h08);
    wr(8'h08, 0);
    wr(8'h14, 32'hFF);
`endif

    // Event set coincident with W1C of the same bit
    k = cyc;
    irq_raw[5] = 1'b1;
    expi(k + 4, 8'h20, 8'h20);
    tick(3);
    wr(8'h14, 32'h20);
    rd(8'h14, 32'h20);
    wr(8'h14, 32'h20);
    rd(8'h14, 0);
    irq_raw[5] = 1'b0;
    tick(6);

    // Async reset while int_out=0xFF, a read in flight and a debounce running
    wr(8'h08, 32'h03);
    wr(8'h04, 32'hFF);
    expi(cyc + 3, 8'hFF, 8'hFF);
    tick(4);
    k = cyc;
    irq_raw = 8'h80;
    expi(k + 2, 8'hFF, 8'hFF);
    expi(k + 3, 8'hFF, 8'h00);
    tick(2);
    wb_addr = 8'h0C; wb_we = 1'b0; wb_stb = 1'b1;
    tick(1);
    rst_n = 1'b0; wb_stb = 1'b0; irq_raw = '0;
    #1;
    chk("rst_ack", {31'h0, wb_ack}, 32'h0);
    chk("rst_rdata", wb_rdata, 32'h0);
    tick(2);
    rst_n = 1'b1;
    j = cyc;
    for (int c = 1; c <= 8; c++) expi(j + c, 8'hFF, 8'h00);
    tick(1);
    rd(8'h04, 0);
    rd(8'h14, 0);
    rd(8'h08, 0);
    rd(8'h00, 0);
    tick(8);

    for (int i = 0; i < 50 && (iq.size() > 0 || bq.size() > 0); i++) tick(1);
    while (iq.size() > 0) begin
      ie = iq.pop_front();
      n_chk++;
      $display("FAIL int_out sample cyc=%0d never reached", ie.cyc);
    end
    while (bq.size() > 0) begin
      be = bq.pop_front();
      n_chk++;
      $display("FAIL wb_ack missing addr=%h exp cyc=%0d", be.addr, be.cyc);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
